// File: rtl/motor_pwm_multi.sv
// rtl/motor_pwm_multi.sv - multi-channel soft-start motor PWM with shared period counter and 7-seg readout
module motor_pwm_multi #(
    parameter int CHANNELS     = 2,
    parameter int PERIOD       = 1000,
    parameter int SPEED_MAX    = 10,
    parameter int SPEED_W      = 4,
    parameter int RAMP_PERIODS = 4
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [CHANNELS*SPEED_W-1:0]                   speed,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] disp_sel,
    output logic [CHANNELS-1:0]                           pwm_out,
    output logic [CHANNELS-1:0]                           at_target,
    output logic                                          period_start,
    output logic [6:0]                                    seven_segment
);

    localparam int CW   = $clog2(PERIOD);
    localparam int DW   = $clog2(PERIOD + 1);
    localparam int RW   = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int STEP = PERIOD / SPEED_MAX;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    logic                enable_q;
    logic [CW-1:0]       counter, counter_n;
    logic [RW-1:0]       ramp_cnt, ramp_n;
    logic [SPEED_W-1:0]  cur_speed [CHANNELS];
    logic [SPEED_W-1:0]  cur_n     [CHANNELS];
    logic [SPEED_W-1:0]  tgt       [CHANNELS];
    logic [DW-1:0]       duty      [CHANNELS];
    logic [DW-1:0]       duty_n    [CHANNELS];
    logic [CHANNELS-1:0] pwm_n, at_n;
    logic                period_start_n;
    logic [6:0]          seg_n;
    logic                boundary, ramp_step;

    function automatic logic [6:0] seg_of(input logic [SPEED_W-1:0] v);
        logic [6:0] s;
        if (int'(v) > 15) begin
            s = SEG_DASH;
        end else begin
            case (4'(v))
                4'h0:    s = 7'b1000000;
                4'h1:    s = 7'b1111001;
                4'h2:    s = 7'b0100100;
                4'h3:    s = 7'b0110000;
                4'h4:    s = 7'b0011001;
                4'h5:    s = 7'b0010010;
                4'h6:    s = 7'b0000010;
                4'h7:    s = 7'b1111000;
                4'h8:    s = 7'b0000000;
                4'h9:    s = 7'b0010000;
                4'hA:    s = 7'b0001000;
                4'hB:    s = 7'b0000011;
                4'hC:    s = 7'b1000110;
                4'hD:    s = 7'b0100001;
                4'hE:    s = 7'b0000110;
                default: s = 7'b0001110;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        counter_n = '0;
        ramp_n    = '0;
        boundary  = 1'b0;
        ramp_step = 1'b0;
        // The first enabled cycle holds counter at 0 so period_start fires on (re)start.
        if (enable && enable_q) begin
            if (counter == CW'(PERIOD - 1)) begin
                boundary = 1'b1;
            end else begin
                counter_n = counter + CW'(1);
            end
        end
        if (boundary) begin
            if (ramp_cnt == RW'(RAMP_PERIODS - 1)) begin
                ramp_step = 1'b1;
            end else begin
                ramp_n = ramp_cnt + RW'(1);
            end
        end else if (enable) begin
            ramp_n = ramp_cnt;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            tgt[i] = speed[i*SPEED_W +: SPEED_W];
            if (int'(tgt[i]) > SPEED_MAX) tgt[i] = SPEED_W'(SPEED_MAX);
            cur_n[i]  = '0;
            duty_n[i] = '0;
            if (enable) begin
                cur_n[i]  = cur_speed[i];
                duty_n[i] = duty[i];
                if (boundary) begin
                    if (ramp_step) begin
                        if (cur_speed[i] < tgt[i]) cur_n[i] = cur_speed[i] + SPEED_W'(1);
                        else if (cur_speed[i] > tgt[i]) cur_n[i] = cur_speed[i] - SPEED_W'(1);
                    end
                    duty_n[i] = DW'(cur_n[i]) * DW'(STEP);
                end
            end
            pwm_n[i] = enable && (DW'(counter_n) < duty_n[i]);
            at_n[i]  = (cur_n[i] == tgt[i]);
        end

        period_start_n = enable && (counter_n == '0);
        if (int'(disp_sel) >= CHANNELS) seg_n = SEG_DASH;
        else                            seg_n = seg_of(cur_n[disp_sel]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            enable_q      <= 1'b0;
            counter       <= '0;
            ramp_cnt      <= '0;
            pwm_out       <= '0;
            at_target     <= '0;
            period_start  <= 1'b0;
            seven_segment <= SEG_ZERO;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_speed[i] <= '0;
                duty[i]      <= '0;
            end
        end else begin
            enable_q      <= enable;
            counter       <= counter_n;
            ramp_cnt      <= ramp_n;
            pwm_out       <= pwm_n;
            at_target     <= at_n;
            period_start  <= period_start_n;
            seven_segment <= seg_n;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_speed[i] <= cur_n[i];
                duty[i]      <= duty_n[i];
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// tb/tb_motor_pwm_multi.sv - randomized self-checking bench for motor_pwm_multi
module tb_motor_pwm_multi;

    localparam int CH   = 2;
    localparam int PER  = 20;
    localparam int SMAX = 10;
    localparam int SW   = 4;
    localparam int RAMP = 2;
    localparam int STEP = PER / SMAX;
    localparam logic [6:0] DASH = 7'b0111111;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [CH*SW-1:0] speed = '0;
    logic [0:0]     disp_sel = '0;
    logic [CH-1:0]  pwm_out, at_target;
    logic           period_start;
    logic [6:0]     seven_segment;

    int errors = 0;
    int checks = 0;

    motor_pwm_multi #(
        .CHANNELS(CH), .PERIOD(PER), .SPEED_MAX(SMAX), .SPEED_W(SW), .RAMP_PERIODS(RAMP)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .speed(speed), .disp_sel(disp_sel),
        .pwm_out(pwm_out), .at_target(at_target), .period_start(period_start),
        .seven_segment(seven_segment)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: position within the period, completed periods since enable, applied speeds.
    int   m_pos = 0;
    int   m_periods = 0;
    int   m_cur [CH];
    bit   m_enq = 0;
    bit   started = 0;
    logic [CH-1:0] e_pwm, e_at;
    logic          e_ps;
    logic [6:0]    e_seg;

    task automatic model_edge();
        int tgt [CH];
        for (int i = 0; i < CH; i++) begin
            tgt[i] = int'(speed[i*SW +: SW]);
            if (tgt[i] > SMAX) tgt[i] = SMAX;
        end
        if (!reset) begin
            m_enq = 0; m_pos = 0; m_periods = 0;
            for (int i = 0; i < CH; i++) m_cur[i] = 0;
            e_pwm = '0; e_at = '0; e_ps = 1'b0; e_seg = seg_tab[0];
        end else begin
            if (!enable) begin
                m_pos = 0; m_periods = 0;
                for (int i = 0; i < CH; i++) m_cur[i] = 0;
            end else if (!m_enq) begin
                m_pos = 0;
            end else if (m_pos == PER - 1) begin
                m_pos = 0;
                m_periods++;
                if (m_periods % RAMP == 0)
                    for (int i = 0; i < CH; i++)
                        m_cur[i] += (tgt[i] > m_cur[i]) ? 1 : (tgt[i] < m_cur[i]) ? -1 : 0;
            end else begin
                m_pos++;
            end
            m_enq = enable;
            for (int i = 0; i < CH; i++) begin
                e_pwm[i] = enable && (m_pos < m_cur[i] * STEP);
                e_at[i]  = (m_cur[i] == tgt[i]);
            end
            e_ps  = enable && (m_pos == 0);
            e_seg = (int'(disp_sel) >= CH) ? DASH : seg_tab[m_cur[disp_sel]];
        end
        started = 1;
    endtask

    always @(posedge clock) model_edge();

    always @(negedge clock) begin
        if (started) begin
            chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
            chk("at_target", 32'(at_target), 32'(e_at));
            chk("period_start", 32'(period_start), 32'(e_ps));
            chk("seven_segment", 32'(seven_segment), 32'(e_seg));
        end
    end

    task automatic wait_pos(input int p);
        int k = 0;
        while (m_pos != p && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (m_pos != p) chk("wait_pos_timeout", 32'(m_pos), 32'(p));
    endtask

    task automatic count_high(input int ch, output int n);
        wait_pos(0);
        n = 0;
        for (int c = 0; c < PER; c++) begin
            n += int'(pwm_out[ch]);
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; enable = 1'b1; speed = {4'd0, 4'd7};
        repeat (3) @(negedge clock);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);
        chk("rst_seg", 32'(seven_segment), 32'b1000000);

        speed = {4'd5, 4'd10};
        reset = 1'b1;
        @(negedge clock);
        chk("first_ps", 32'(period_start), 32'd1);

        count_high(0, n); chk("p1_high0", 32'(n), 32'd0);
        count_high(0, n); chk("p2_high0", 32'(n), 32'd0);
        count_high(0, n); chk("p3_high0", 32'(n), 32'd2);
        repeat (PER * 18) @(negedge clock);
        count_high(0, n); chk("full_high0", 32'(n), 32'd20);
        chk("at_target0", 32'(at_target[0]), 32'd1);
        chk("seg_ten", 32'(seven_segment), 32'b0001000);
        count_high(1, n); chk("half_high1", 32'(n), 32'd10);
        chk("at_target1", 32'(at_target[1]), 32'd1);

        speed[7:4] = 4'd15;
        repeat (PER * 12) @(negedge clock);
        count_high(1, n); chk("clamp_high1", 32'(n), 32'd20);
        chk("clamp_at1", 32'(at_target[1]), 32'd1);

        wait_pos(7);
        speed[3:0] = 4'd4;
        repeat (PER * 14) @(negedge clock);
        count_high(0, n); chk("down_high0", 32'(n), 32'd8);
        chk("down_at0", 32'(at_target[0]), 32'd1);

        wait_pos(12);
        enable = 1'b0;
        @(negedge clock);
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        chk("dis_ps", 32'(period_start), 32'd0);
        chk("dis_seg", 32'(seven_segment), 32'b1000000);
        enable = 1'b1;
        @(negedge clock);
        chk("reen_ps", 32'(period_start), 32'd1);
        count_high(0, n); chk("reen_p1", 32'(n), 32'd0);
        count_high(0, n); chk("reen_p2", 32'(n), 32'd0);
        count_high(0, n); chk("reen_p3", 32'(n), 32'd2);

        speed[7:4] = 4'd3;
        disp_sel = 1'b1;
        repeat (PER * 6) @(negedge clock);
        chk("seg_three", 32'(seven_segment), 32'b0110000);

        wait_pos(9);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
        chk("mid_rst_at", 32'(at_target), 32'd0);
        chk("mid_rst_seg", 32'(seven_segment), 32'b1000000);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ps", 32'(period_start), 32'd1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) speed = 8'($urandom);
            if ($urandom_range(0, 49) == 0) disp_sel = 1'($urandom);
            if ($urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 499) != 0);
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_multi.md
Name: motor_pwm_multi

Overview:
- Multi-channel successor to the single-channel motor speed PWM block.
- Drives CHANNELS independent PWM outputs from a shared period counter.
- Each channel soft-starts: its applied speed ramps one step toward the requested speed every RAMP_PERIODS PWM periods.
- Duty updates only at period boundaries, so no output glitches. A seven-segment display shows the applied speed of a selectable channel.

Parameters:
- CHANNELS, 2: number of PWM channels (≥1).
- PERIOD, 1000: clock cycles per PWM period (≥2). Must be a multiple of SPEED_MAX.
- SPEED_MAX, 10: maximum normalized speed.
- SPEED_W, 4: bits per channel speed field.
- RAMP_PERIODS, 4: PWM periods per ramp step (≥1).

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- enable, in, 1: global run enable.
- speed, in, CHANNELS*SPEED_W: requested speed; channel i occupies bits [i*SPEED_W +: SPEED_W].
- disp_sel, in, max(1,$clog2(CHANNELS)): channel shown on the display.
- pwm_out, out, CHANNELS: PWM outputs, bit i = channel i.
- at_target, out, CHANNELS: applied speed equals clamped requested speed.
- period_start, out, 1: high during the cycle in which counter == 0 while enabled.
- seven_segment, out, 7: active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset==0 at a clock edge) sets every register to 0:
  - counter, ramp_cnt, cur_speed[i], duty[i], pwm_out, at_target, period_start.
  - seven_segment = 1000000 (digit 0).
  - Reset overrides everything, including mid-period.
- STEP = PERIOD/SPEED_MAX.
- Target: tgt[i] = min(speed field i, SPEED_MAX). Values above SPEED_MAX clamp.
- Counter: while enable, counts 0..PERIOD-1 and wraps to 0.
- Period boundary = edge at which counter == PERIOD-1 and enable. At that edge:
  - ramp_cnt increments.
  - If ramp_cnt == RAMP_PERIODS-1: ramp_cnt wraps to 0 and each cur_speed[i] moves by exactly 1 toward tgt[i] sampled at that edge (up or down; unchanged if equal).
  - duty[i] loads (new cur_speed[i])*STEP, so the period starting at counter 0 uses the updated duty.
- Between boundaries, duty and cur_speed are frozen. Speed input changes mid-period have no effect until the next boundary.
- Output registers satisfy, in every cycle:
  - pwm_out[i] == enable_q && (counter < duty[i]).
  - period_start == enable_q && (counter == 0).
  - Implemented as registers fed from next-state values; no combinational path from inputs to outputs.
  - Duty 0 gives constant low. Duty PERIOD gives constant high.
- enable low at an edge:
  - Next cycle: counter = 0, ramp_cnt = 0, all cur_speed and duty = 0, pwm_out = 0, period_start = 0.
  - On re-enable, ramp restarts from 0 and counting starts at 0 (period_start high in the first enabled cycle).
- at_target[i] is registered each cycle as (next cur_speed[i] == tgt[i]), with the same one-register alignment as pwm_out.
- Display: registered each cycle from the next cur_speed[disp_sel]:
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - 10-15 show hex A,b,C,d,E,F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Values >15, or disp_sel ≥ CHANNELS, show dash 0111111.
- Widths:
  - Counter width $clog2(PERIOD).
  - Duty width $clog2(PERIOD+1).
  - cur_speed width SPEED_W.
  - Product computed at duty width; no truncation.

Test Plan (CHANNELS=2, PERIOD=20, SPEED_MAX=10, SPEED_W=4, RAMP_PERIODS=2, STEP=2):
1. Hold reset low 3 cycles, enable=1, speed ch0=7 -> all outputs 0 and seven_segment=1000000 during reset. First cycle after release: period_start=1, counter=0.
2. enable=1, ch0 speed=10 from reset -> cur_speed0 becomes 1 at the boundary ending period 2 (period 3 has pwm_out[0] high 2 of 20 cycles). Reaches 10 after 20 periods (400 cycles): pwm_out[0] constantly high, at_target[0]=1, display 0001000.
3. ch1 speed=5 concurrently -> pwm_out[1] high exactly 10 of 20 cycles from period 11 onward, at_target[1]=1. ch1 speed=15 -> ramps and clamps at 10, never exceeds 20/20.
4. At steady speed 10, set ch0 speed=4 at counter=7 -> current period unchanged (20 high). Ramps down one step every 2 periods to 4 (8 high per period), with no runt pulses.
5. enable=0 at counter=12 with duty=8 -> next cycle pwm_out=00, period_start=0, display 1000000. Re-enable -> ramp restarts from 0.
6. disp_sel=1 with ch1 at 3 -> 0110000. Mid-period reset low for 1 cycle -> all registers 0 the next cycle, period restarts at counter 0.
